// File: rtl/sc_reg_countdown.sv
// Loadable down-counter with programmable prescaler, one-cycle terminal-count
// pulse and optional auto-reload of the last loaded value.
module sc_reg_countdown #(
  parameter int RegCOUNTDOWN_DATAWIDTH  = 8,
  parameter int RegCOUNTDOWN_PRESCALE   = 1,
  parameter int RegCOUNTDOWN_AUTORELOAD = 0
) (
  input  logic                              SC_RegCOUNTDOWN_CLOCK_50,
  input  logic                              SC_RegCOUNTDOWN_RESET_InLow,
  input  logic                              SC_RegCOUNTDOWN_clear_InLow,
  input  logic                              SC_RegCOUNTDOWN_load_InLow,
  input  logic                              SC_RegCOUNTDOWN_enable_InLow,
  input  logic [RegCOUNTDOWN_DATAWIDTH-1:0] SC_RegCOUNTDOWN_data_InBUS,
  output logic [RegCOUNTDOWN_DATAWIDTH-1:0] SC_RegCOUNTDOWN_data_OutBUS,
  output logic                              SC_RegCOUNTDOWN_zero_OutLow,
  output logic                              SC_RegCOUNTDOWN_tc_OutHigh,
  output logic                              SC_RegCOUNTDOWN_running_OutHigh
);

  localparam int W = RegCOUNTDOWN_DATAWIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, stateNext;
  logic [W-1:0]   count, countNext;
  logic [W-1:0]   reload, reloadNext;
  logic           tc, tcNext;
  logic           advance;
  logic           presWrap;

  // An enabled RUN cycle; clear/load override it through priority below.
  assign advance = (state == RUN) && !SC_RegCOUNTDOWN_enable_InLow;

  generate
    if (RegCOUNTDOWN_PRESCALE > 1) begin : gPres
      localparam int PW = $clog2(RegCOUNTDOWN_PRESCALE);
      logic [PW-1:0] pres;

      assign presWrap = (pres == PW'(RegCOUNTDOWN_PRESCALE - 1));

      always_ff @(posedge SC_RegCOUNTDOWN_CLOCK_50 or negedge SC_RegCOUNTDOWN_RESET_InLow) begin
        if (!SC_RegCOUNTDOWN_RESET_InLow) begin
          pres <= '0;
        end else if (!SC_RegCOUNTDOWN_clear_InLow || !SC_RegCOUNTDOWN_load_InLow) begin
          pres <= '0;
        end else if (advance) begin
          pres <= presWrap ? '0 : pres + 1'b1;
        end
      end
    end else begin : gNoPres
      assign presWrap = 1'b1;
    end
  endgenerate

  always_ff @(posedge SC_RegCOUNTDOWN_CLOCK_50 or negedge SC_RegCOUNTDOWN_RESET_InLow) begin
    if (!SC_RegCOUNTDOWN_RESET_InLow) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= stateNext;
      count  <= countNext;
      reload <= reloadNext;
      tc     <= tcNext;
    end
  end

  always_comb begin
    stateNext  = state;
    countNext  = count;
    reloadNext = reload;
    tcNext     = 1'b0;
    if (!SC_RegCOUNTDOWN_clear_InLow) begin
      stateNext = IDLE;
      countNext = '0;
    end else if (!SC_RegCOUNTDOWN_load_InLow) begin
      countNext  = SC_RegCOUNTDOWN_data_InBUS;
      reloadNext = SC_RegCOUNTDOWN_data_InBUS;
      stateNext  = (SC_RegCOUNTDOWN_data_InBUS != '0) ? RUN : DONE;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (advance && presWrap) begin
            if (count > W'(1)) begin
              countNext = count - 1'b1;
            end else if (RegCOUNTDOWN_AUTORELOAD != 0) begin
              countNext = reload;
              tcNext    = 1'b1;
            end else begin
              countNext = '0;
              stateNext = DONE;
              tcNext    = 1'b1;
            end
          end
        end
        DONE:    countNext = '0;
        default: stateNext = IDLE;
      endcase
    end
  end

  assign SC_RegCOUNTDOWN_data_OutBUS     = count;
  assign SC_RegCOUNTDOWN_zero_OutLow     = (count != '0);
  assign SC_RegCOUNTDOWN_tc_OutHigh      = tc;
  assign SC_RegCOUNTDOWN_running_OutHigh = (state == RUN);

endmodule
